// File: rtl/wave_pkg.sv
// wave_pkg: shared types, widths and helpers for the waveform capture path
package wave_pkg;
    localparam int SAMPLE_W = 32;
    localparam int TIME_W = 64;
    typedef enum logic [1:0] {CHIRP = 2'd0, TONE = 2'd1, RAMP = 2'd2} wave_type_t;
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} rx_state_t;
    function automatic logic [SAMPLE_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] x);
        return !x[SAMPLE_W-1] ? x :
               (x == {1'b1, {(SAMPLE_W-1){1'b0}}}) ? {1'b0, {(SAMPLE_W-1){1'b1}}} : -x;
    endfunction
endpackage

// File: rtl/wave_rx_capture_if.sv
// wave_rx_capture_if: sample stream in plus FIFO readout port
interface wave_rx_capture_if;
    import wave_pkg::*;
    logic [SAMPLE_W-1:0] i_tdata1;
    logic [SAMPLE_W-1:0] i_tdata2;
    logic i_tvalid;
    logic i_tready;
    logic rd_en;
    logic [2*SAMPLE_W-1:0] rd_data;
    logic rd_empty;
    modport master (output i_tdata1, i_tdata2, i_tvalid, rd_en, input i_tready, rd_data, rd_empty);
    modport slave (input i_tdata1, i_tdata2, i_tvalid, rd_en, output i_tready, rd_data, rd_empty);
endinterface

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous first-word-fall-through FIFO with wrap-bit pointers
module sample_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic full_q, full_d, empty_q, empty_d;
    logic do_push, do_pop;
    assign do_push = push_i & ~full_q;
    assign do_pop = pop_i & ~empty_q;
    always_comb begin
        wptr_d = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
        empty_d = wptr_d == rptr_d;
        full_d = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            full_q <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            full_q <= full_d;
            empty_q <= empty_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
    // stale storage is masked so the head reads zero while empty
    assign rdata_o = empty_q ? '0 : mem_q[rptr_q[AW-1:0]];
    assign full_o = full_q;
    assign empty_o = empty_q;
endmodule

// File: rtl/wave_rx_capture.sv
// wave_rx_capture: triggered one-PRI stream sink with FIFO buffering and status
module wave_rx_capture import wave_pkg::*; #(
    parameter int DEPTH = 16
) (
    input  logic sClk,
    input  logic reset,
    input  logic sRun,
    input  logic [TIME_W-1:0] vita_time,
    input  logic [TIME_W-1:0] vita_time_trigger,
    input  logic [31:0] len_PRI,
    input  logic [31:0] duration_wave,
    wave_rx_capture_if.slave s,
    output logic [31:0] o_beat_count,
    output logic [15:0] o_tail_err,
    output logic [SAMPLE_W-1:0] o_peak,
    output logic [TIME_W-1:0] o_first_time,
    output logic o_done,
    output logic o_abort
);
    rx_state_t state_q, state_d;
    logic [31:0] len_q, len_d, dur_q, dur_d, cnt_q, cnt_d;
    logic [15:0] tail_q, tail_d;
    logic [SAMPLE_W-1:0] peak_q, peak_d, mag;
    logic [TIME_W-1:0] first_q, first_d;
    logic abort_q, abort_d;
    logic fifo_full, accept, active, last;
    assign s.i_tready = (state_q == CAPTURE) & ~fifo_full;
    assign accept = s.i_tvalid & s.i_tready;
    assign active = cnt_q < dur_q;
    assign last = cnt_q == len_q - 32'd1;
    assign mag = abs_sat(s.i_tdata1);
    always_comb begin
        state_d = state_q;
        len_d = len_q;
        dur_d = dur_q;
        cnt_d = cnt_q;
        tail_d = tail_q;
        peak_d = peak_q;
        first_d = first_q;
        abort_d = 1'b0;
        case (state_q)
            IDLE: if (sRun) begin
                state_d = ARMED;
                len_d = len_PRI;
                dur_d = duration_wave;
                cnt_d = '0;
                tail_d = '0;
                peak_d = '0;
                first_d = '0;
            end
            ARMED: if (!sRun) state_d = IDLE;
                   else if (vita_time >= vita_time_trigger) state_d = (len_q == '0) ? DONE : CAPTURE;
            // the last beat wins over a simultaneous sRun drop
            CAPTURE: if (accept && last) state_d = DONE;
                     else if (!sRun) begin
                         state_d = IDLE;
                         abort_d = 1'b1;
                     end
            DONE: if (!sRun) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            cnt_d = cnt_q + 32'd1;
            if (cnt_q == '0) first_d = vita_time;
            if (active) peak_d = (mag > peak_q) ? mag : peak_q;
            else if (((s.i_tdata1 | s.i_tdata2) != '0) && (tail_q != 16'hFFFF)) tail_d = tail_q + 16'd1;
        end
    end
    always_ff @(posedge sClk) begin
        if (!reset) begin
            state_q <= IDLE;
            len_q <= '0;
            dur_q <= '0;
            cnt_q <= '0;
            tail_q <= '0;
            peak_q <= '0;
            first_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            dur_q <= dur_d;
            cnt_q <= cnt_d;
            tail_q <= tail_d;
            peak_q <= peak_d;
            first_q <= first_d;
            abort_q <= abort_d;
        end
    end
    sample_fifo #(.WIDTH(2 * SAMPLE_W), .DEPTH(DEPTH)) u_fifo (
        .clk_i(sClk),
        .rst_ni(reset),
        .push_i(accept & active),
        .pop_i(s.rd_en),
        .wdata_i({s.i_tdata2, s.i_tdata1}),
        .rdata_o(s.rd_data),
        .full_o(fifo_full),
        .empty_o(s.rd_empty)
    );
    assign o_beat_count = cnt_q;
    assign o_tail_err = tail_q;
    assign o_peak = peak_q;
    assign o_first_time = first_q;
    assign o_done = state_q == DONE;
    assign o_abort = abort_q;
endmodule

// File: tb/tb_wave_rx_capture.sv
// tb_wave_rx_capture: table-driven PRIs plus corner sequences with a FIFO scoreboard
module tb_wave_rx_capture;
    import wave_pkg::*;
    localparam int D = 16;
    typedef struct {
        int len;
        int dur;
        int mode;
        int cnt;
        int tail;
        logic [31:0] peak;
        int fifo;
    } vec_t;
    logic sClk = 1'b0;
    logic reset = 1'b0;
    logic sRun = 1'b0;
    logic [63:0] vita_time = '0;
    logic [63:0] vita_time_trigger = 64'd100;
    logic [31:0] len_PRI = '0;
    logic [31:0] duration_wave = '0;
    logic [31:0] o_beat_count;
    logic [15:0] o_tail_err;
    logic [31:0] o_peak;
    logic [63:0] o_first_time;
    logic o_done, o_abort;
    wave_rx_capture_if bus();
    wave_rx_capture #(.DEPTH(D)) dut (
        .sClk(sClk),
        .reset(reset),
        .sRun(sRun),
        .vita_time(vita_time),
        .vita_time_trigger(vita_time_trigger),
        .len_PRI(len_PRI),
        .duration_wave(duration_wave),
        .s(bus),
        .o_beat_count(o_beat_count),
        .o_tail_err(o_tail_err),
        .o_peak(o_peak),
        .o_first_time(o_first_time),
        .o_done(o_done),
        .o_abort(o_abort)
    );
    always #5 sClk = ~sClk;
    int total = 0;
    int bad = 0;
    int mcnt = 0;
    int mdur = 0;
    int cur_mode = 0;
    int npop = 0;
    logic [63:0] q[$];
    vec_t vt[5];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask
    function automatic logic [63:0] beat(input int mode, input int k, input int dur);
        case (mode)
            0: return k < dur ? {32'd0, 32'(k + 1)} : 64'd0;
            1: return k < dur ? {32'(k), 32'(k + 1)} : (k == 3 || k == 5) ? {32'd1, 32'd0} : 64'd0;
            2: return k == 2 ? {32'd0, 32'h8000_0000} : {32'd7, 32'(-(k + 1))};
            3: return {32'd0, 32'(k & 1)};
            default: return 64'd0;
        endcase
    endfunction
    task automatic step();
        @(posedge sClk);
        @(negedge sClk);
    endtask
    task automatic cycle();
        logic acc, pop;
        logic [63:0] exp;
        acc = bus.i_tvalid && bus.i_tready;
        pop = bus.rd_en && !bus.rd_empty;
        if (pop) begin
            npop++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra_pop got=%0h want=none", bus.rd_data);
            end else begin
                exp = q.pop_front();
                chk("rd_data", bus.rd_data, exp);
            end
        end
        step();
        vita_time++;
        if (acc) begin
            if (mcnt < mdur) q.push_back({bus.i_tdata2, bus.i_tdata1});
            mcnt++;
        end
        {bus.i_tdata2, bus.i_tdata1} = beat(cur_mode, mcnt, mdur);
    endtask
    task automatic arm(input int len, input int dur, input int mode);
        sRun = 1'b0;
        bus.rd_en = 1'b0;
        bus.i_tvalid = 1'b0;
        step();
        mcnt = 0;
        mdur = dur;
        cur_mode = mode;
        len_PRI = 32'(len);
        duration_wave = 32'(dur);
        vita_time = 64'd90;
        {bus.i_tdata2, bus.i_tdata1} = beat(mode, 0, dur);
        bus.i_tvalid = 1'b1;
        sRun = 1'b1;
    endtask
    task automatic drain(output int n);
        int p0;
        p0 = npop;
        bus.i_tvalid = 1'b0;
        bus.rd_en = 1'b1;
        for (int c = 0; c < 64 && !bus.rd_empty; c++) cycle();
        bus.rd_en = 1'b0;
        n = npop - p0;
    endtask
    task automatic chk_reset(input string p);
        chk({p, "_tready"}, bus.i_tready, 0);
        chk({p, "_empty"}, bus.rd_empty, 1);
        chk({p, "_rd_data"}, bus.rd_data, 0);
        chk({p, "_cnt"}, o_beat_count, 0);
        chk({p, "_tail"}, o_tail_err, 0);
        chk({p, "_peak"}, o_peak, 0);
        chk({p, "_first"}, o_first_time, 0);
        chk({p, "_done"}, o_done, 0);
        chk({p, "_abort"}, o_abort, 0);
    endtask
    initial begin
        int n, hi;
        logic [63:0] v;
        vt[0] = '{len: 8, dur: 5, mode: 0, cnt: 8, tail: 0, peak: 32'd5, fifo: 5};
        vt[1] = '{len: 6, dur: 3, mode: 1, cnt: 6, tail: 2, peak: 32'd3, fifo: 3};
        vt[2] = '{len: 4, dur: 4, mode: 2, cnt: 4, tail: 0, peak: 32'h7FFF_FFFF, fifo: 4};
        vt[3] = '{len: 3, dur: 10, mode: 0, cnt: 3, tail: 0, peak: 32'd3, fifo: 3};
        vt[4] = '{len: 5, dur: 0, mode: 3, cnt: 5, tail: 2, peak: 32'd0, fifo: 0};
        bus.i_tdata1 = '0;
        bus.i_tdata2 = '0;
        bus.i_tvalid = 1'b0;
        bus.rd_en = 1'b0;
        step();
        step();
        chk_reset("rst");
        reset = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            arm(vt[i].len, vt[i].dur, vt[i].mode);
            for (int c = 0; c < 200 && !o_done; c++) cycle();
            chk($sformatf("v%0d_done", i), o_done, 1);
            chk($sformatf("v%0d_cnt", i), o_beat_count, 64'(vt[i].cnt));
            chk($sformatf("v%0d_tail", i), o_tail_err, 64'(vt[i].tail));
            chk($sformatf("v%0d_peak", i), o_peak, 64'(vt[i].peak));
            chk($sformatf("v%0d_first", i), o_first_time, 64'd101);
            drain(n);
            chk($sformatf("v%0d_fifo_n", i), 64'(n), 64'(vt[i].fifo));
            chk($sformatf("v%0d_sb_left", i), 64'(q.size()), 0);
        end
        arm(D + 6, D + 6, 0);
        for (int c = 0; c < 100 && mcnt < D; c++) cycle();
        for (int c = 0; c < 3; c++) cycle();
        chk("bp_accepted", 64'(mcnt), 64'(D));
        chk("bp_ready_low", bus.i_tready, 0);
        bus.rd_en = 1'b1;
        cycle();
        cycle();
        bus.rd_en = 1'b0;
        for (int c = 0; c < 4; c++) cycle();
        chk("bp_after_pop2", 64'(mcnt), 64'(D + 2));
        chk("bp_ready_low2", bus.i_tready, 0);
        bus.rd_en = 1'b1;
        for (int c = 0; c < 100 && !o_done; c++) cycle();
        chk("bp_done", o_done, 1);
        drain(n);
        chk("bp_cnt", o_beat_count, 64'(D + 6));
        chk("bp_sb_left", 64'(q.size()), 0);
        arm(8, 8, 0);
        for (int c = 0; c < 100 && mcnt < 3; c++) cycle();
        sRun = 1'b0;
        bus.i_tvalid = 1'b0;
        cycle();
        chk("ab_pulse", o_abort, 1);
        chk("ab_cnt", o_beat_count, 3);
        chk("ab_peak", o_peak, 3);
        chk("ab_done", o_done, 0);
        chk("ab_tready", bus.i_tready, 0);
        cycle();
        chk("ab_pulse_end", o_abort, 0);
        vita_time = '0;
        sRun = 1'b1;
        cycle();
        chk("ab_rearm_cnt", o_beat_count, 0);
        chk("ab_rearm_peak", o_peak, 0);
        chk("ab_fifo_kept", bus.rd_empty, 0);
        sRun = 1'b0;
        cycle();
        drain(n);
        chk("ab_fifo_n", 64'(n), 3);
        arm(0, 0, 0);
        hi = 0;
        for (int c = 0; c < 20; c++) begin
            v = vita_time;
            if (bus.i_tready) hi++;
            cycle();
            if (v == 64'd99) chk("len0_done_early", o_done, 0);
            if (v == 64'd100) chk("len0_done", o_done, 1);
        end
        chk("len0_ready", 64'(hi), 0);
        chk("len0_beats", 64'(mcnt), 0);
        arm(2, 2, 0);
        for (int c = 0; c < 100 && mcnt < 1; c++) cycle();
        sRun = 1'b0;
        cycle();
        chk("sim_accepted", 64'(mcnt), 2);
        chk("sim_done", o_done, 1);
        chk("sim_no_abort", o_abort, 0);
        bus.i_tvalid = 1'b0;
        cycle();
        chk("sim_idle", o_done, 0);
        drain(n);
        chk("sim_fifo_n", 64'(n), 2);
        arm(8, 8, 0);
        for (int c = 0; c < 100 && mcnt < 4; c++) cycle();
        chk("mid_reach", 64'(mcnt), 4);
        reset = 1'b0;
        step();
        chk_reset("mid");
        reset = 1'b1;
        sRun = 1'b0;
        bus.i_tvalid = 1'b0;
        q.delete();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wave_rx_capture.md
# wave_rx_capture

AXI-stream-style sink for the sample stream produced by the waveform generator (tdata1/tdata2/tvalid/tready). Once armed by `sRun` and released at a VITA-time trigger, it accepts exactly one PRI of beats, counted against a latched `len_PRI`. Beats in the active window (the first `duration_wave` beats) are buffered in a FIFO for downstream readout. Beats in the tail are checked for zero. Status registers expose the beat count, tail errors, peak amplitude and first-beat timestamp.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `sClk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `sRun` in 1: arm / keep-alive level.
- `vita_time` in 64: current time.
- `vita_time_trigger` in 64: capture start time.
- `len_PRI` in 32: beats per PRI; latched on arm.
- `duration_wave` in 32: active-window beats; latched on arm.
- `i_tdata1` in 32: sample word 1.
- `i_tdata2` in 32: sample word 2.
- `i_tvalid` in 1: beat valid.
- `i_tready` out 1: beat ready.
- `rd_en` in 1: pop FIFO head; ignored when empty.
- `rd_data` out 64: FIFO head, `{tdata2, tdata1}`; first-word-fall-through.
- `rd_empty` out 1: FIFO empty.
- `o_beat_count` out 32: beats accepted this PRI.
- `o_tail_err` out 16: non-zero tail beats; saturating.
- `o_peak` out 32: max |`i_tdata1`| (signed) over active beats.
- `o_first_time` out 64: `vita_time` at the first accepted beat.
- `o_done` out 1: PRI complete (level).
- `o_abort` out 1: one-cycle pulse when `sRun` drops mid-capture.

## Operation
- **States:** IDLE, ARMED, CAPTURE, DONE.
- **IDLE → ARMED** on `sRun`=1.
  - Latch `len_PRI` and `duration_wave`.
  - Clear `o_beat_count`, `o_tail_err`, `o_peak`, `o_first_time`.
- **ARMED → CAPTURE** when `vita_time >= vita_time_trigger` (unsigned 64-bit compare).
  - If latched len = 0, go directly to DONE instead.
- **Beat acceptance:** a beat is accepted on an edge where `i_tvalid & i_tready`. Beat index k = `o_beat_count` before increment.
- **Active beat (k < durationWave):**
  - Push `{i_tdata2, i_tdata1}` into the FIFO.
  - Update `o_peak` with |tdata1|. |0x80000000| saturates to 0x7FFFFFFF.
- **Tail beat (k ≥ durationWave):**
  - Not stored.
  - If either word ≠ 0, increment `o_tail_err`, saturating at 0xFFFF.
- **First beat (k = 0):** latch `vita_time` into `o_first_time`.
- **CAPTURE → DONE** on acceptance of beat k = lenPRI−1.
- **DONE:** `o_done`=1. Go to IDLE when `sRun`=0.
- **`sRun` falls in ARMED or CAPTURE:**
  - Go to IDLE.
  - Pulse `o_abort` in CAPTURE only.
  - Statistics are frozen, not cleared.
- **`i_tready`** = (state==CAPTURE) & !fifo_full. Combinational from registered state/full only; never depends on `i_tvalid`.
- **Tail beats and backpressure:** tail beats also require !full. This keeps the ready rule uniform.
- **FIFO lifetime:**
  - The FIFO is never flushed except by reset; readout may span PRIs.
  - Pop and push in the same cycle are both legal, including when full (a pop frees the slot next cycle).
- **Arithmetic:**
  - Counters unsigned.
  - durationWave > lenPRI is legal: all beats are active.

## Timing
- **Reset values:**
  - State IDLE.
  - `i_tready`=0, `rd_empty`=1, `rd_data`=0.
  - All status outputs 0; `o_done`=0, `o_abort`=0.
- **Reset mid-capture:** the FIFO and all state are discarded.
- **Trigger latency:** CAPTURE is entered on the edge where the compare is true. `i_tready` can assert in the next cycle.
- **Statistics:** `o_beat_count`, `o_tail_err`, `o_peak` and `o_first_time` update on the accepting edge and are visible next cycle.
- **FIFO write→read latency:** 1 cycle; `rd_empty` falls the cycle after the push edge.
- **Full flag:** `fifo_full` updates on the push edge, so `i_tready` drops the cycle after the DEPTH-th unpopped push.
- **Sustained throughput:** 1 beat/cycle while not full.
- **`o_done`:** rises the cycle after the last beat's edge.
- **`o_abort`:** high for exactly the cycle after the edge that sampled `sRun`=0.
- **`sRun`=0 simultaneous with the last beat:** the beat is accepted. DONE takes precedence; `o_abort` is not pulsed. The next edge sees `sRun`=0 and goes to IDLE.

## Structure
- **Package `wave_pkg`:**
  - State enum `rx_state_t` (2-bit).
  - Wave-type constants shared with the generator (CHIRP=0, TONE=1, RAMP=2).
  - `SAMPLE_W`=32, `TIME_W`=64.
- **Sub-module `sample_fifo`:**
  - Parameterized synchronous FWFT FIFO (WIDTH, DEPTH).
  - Binary pointers with one extra wrap bit; registered `full`/`empty`.
  - Instantiated once with WIDTH=64.
- The top level holds the FSM, index/stat counters, peak and tail logic.

## Test plan
- **Basic PRI.** len=8, dur=5, trigger=100, vita_time counting from 90, continuous valid.
  - Data beats 1..5, tail beats zero, no reads.
  - Expect: 5 FIFO entries.
  - `o_beat_count`=8, `o_tail_err`=0, `o_peak`=5, `o_first_time`=101, `o_done`=1.
- **Backpressure.** DEPTH=4, len=10, dur=10, `rd_en` low.
  - Expect: `i_tready` low after 4 accepted beats.
  - Pop 2 → exactly 2 more beats accepted.
  - Readout order matches input; no beat dropped or duplicated.
- **Tail error.** len=6, dur=3, beats 4 and 6 carry tdata2=1.
  - Expect: `o_tail_err`=2, 3 FIFO entries.
- **Abort.** `sRun` dropped after beat 3 of len=8.
  - Expect: `o_abort` single pulse, state IDLE, `o_beat_count`=3, `o_done`=0.
  - Re-arm clears the stats; the FIFO retains its 3 entries.
- **Edge cases.**
  - len=0: `o_done` asserts the cycle after the trigger; `i_tready` never asserts.
  - tdata1=0x80000000: `o_peak`=0x7FFFFFFF.
  - Reset asserted mid-capture: all outputs return to reset values next cycle.
